// File: rtl/sramc_port_arbiter.sv
// Two-port arbiter in front of a single-ported SRAMC macro. The core has
// priority; the DMA is protected from starvation by a wait counter that
// forces a one-cycle DMA turn once the programmable limit is reached.
module sramc_port_arbiter #(
  parameter int unsigned SRAMC_W = 96,
  parameter int unsigned ADRC_W  = 8,
  parameter int unsigned SRAMC_N = 2,
  parameter int unsigned WAIT_W  = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  // core side
  input  logic               i_core_req,
  input  logic               i_core_wren,
  input  logic [ADRC_W-1:0]  i_core_addr,
  input  logic [SRAMC_W-1:0] i_core_wdata,
  input  logic [SRAMC_N-1:0] i_core_wmask,
  output logic               o_core_gnt,
  output logic               o_core_rvalid,
  output logic [SRAMC_W-1:0] o_core_rdata,
  // DMA side
  input  logic               i_dma_req,
  input  logic               i_dma_wren,
  input  logic [ADRC_W-1:0]  i_dma_addr,
  input  logic [SRAMC_W-1:0] i_dma_wdata,
  input  logic [SRAMC_N-1:0] i_dma_wmask,
  output logic               o_dma_gnt,
  output logic               o_dma_rvalid,
  output logic [SRAMC_W-1:0] o_dma_rdata,
  // SRAMC side
  output logic               o_sram_rden,
  output logic               o_sram_wren,
  output logic [ADRC_W-1:0]  o_sram_addr,
  output logic [SRAMC_W-1:0] o_sram_wdata,
  output logic [SRAMC_N-1:0] o_sram_wmask,
  input  logic [SRAMC_W-1:0] i_sram_rdata,
  // config / status
  input  logic [WAIT_W-1:0]  i_max_wait,
  input  logic               i_cnt_clear,
  output logic [15:0]        o_conflict_cnt
);

  typedef enum logic [0:0] {
    CORE_PRIO = 1'b0,
    DMA_TURN  = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [WAIT_W:0]     wait_inc;
  logic                core_gnt, dma_gnt;
  logic                core_rvalid_q, dma_rvalid_q;
  logic [15:0]         conflict_q;

  // One extra bit so the limit compare stays correct when wait_q is all-ones.
  assign wait_inc = {1'b0, wait_q} + 1'b1;

  // Grant decision, wait counter and next state.
  always_comb begin
    core_gnt = 1'b0;
    dma_gnt  = 1'b0;
    state_d  = state_q;
    wait_d   = wait_q;
    unique case (state_q)
      CORE_PRIO: begin
        core_gnt = i_core_req;
        dma_gnt  = i_dma_req & ~i_core_req;
        if (dma_gnt) begin
          wait_d = '0;
        end else if (i_dma_req) begin
          if (wait_q != '1) wait_d = wait_q + 1'b1;
          // >= rather than == so lowering the limit mid-run still triggers.
          if ((i_max_wait != '0) && (wait_inc >= {1'b0, i_max_wait}))
            state_d = DMA_TURN;
        end
      end
      DMA_TURN: begin
        dma_gnt  = i_dma_req;
        core_gnt = i_core_req & ~i_dma_req;
        state_d  = CORE_PRIO;
        wait_d   = '0;
      end
      default: begin
        state_d = CORE_PRIO;
        wait_d  = '0;
      end
    endcase
  end

  // FSM state and starvation counter registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= CORE_PRIO;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // SRAM request mux: granted requester's fields, zero when idle.
  always_comb begin
    o_sram_rden  = 1'b0;
    o_sram_wren  = 1'b0;
    o_sram_addr  = '0;
    o_sram_wdata = '0;
    o_sram_wmask = '0;
    if (core_gnt) begin
      o_sram_rden  = ~i_core_wren;
      o_sram_wren  = i_core_wren;
      o_sram_addr  = i_core_addr;
      o_sram_wdata = i_core_wdata;
      o_sram_wmask = i_core_wmask;
    end else if (dma_gnt) begin
      o_sram_rden  = ~i_dma_wren;
      o_sram_wren  = i_dma_wren;
      o_sram_addr  = i_dma_addr;
      o_sram_wdata = i_dma_wdata;
      o_sram_wmask = i_dma_wmask;
    end
  end

  // Read-owner tracking: remembers who issued last cycle's read.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      core_rvalid_q <= 1'b0;
      dma_rvalid_q  <= 1'b0;
    end else begin
      core_rvalid_q <= core_gnt & ~i_core_wren;
      dma_rvalid_q  <= dma_gnt & ~i_dma_wren;
    end
  end

  // Saturating conflict counter; clear has priority over increment.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_cnt_clear) begin
      conflict_q <= '0;
    end else if (i_core_req && i_dma_req && (conflict_q != '1)) begin
      conflict_q <= conflict_q + 16'd1;
    end
  end

  assign o_core_gnt     = core_gnt;
  assign o_dma_gnt      = dma_gnt;
  assign o_core_rvalid  = core_rvalid_q;
  assign o_dma_rvalid   = dma_rvalid_q;
  assign o_core_rdata   = core_rvalid_q ? i_sram_rdata : '0;
  assign o_dma_rdata    = dma_rvalid_q  ? i_sram_rdata : '0;
  assign o_conflict_cnt = conflict_q;

endmodule

// File: tb/tb_sramc_port_arbiter.sv
// Directed bench for sramc_port_arbiter: table of single-cycle grant/mux
// vectors followed by hand-written multi-cycle sequences.
module tb_sramc_port_arbiter;

  localparam int unsigned SRAMC_W = 96;
  localparam int unsigned ADRC_W  = 8;
  localparam int unsigned SRAMC_N = 2;
  localparam int unsigned WAIT_W  = 4;

  localparam logic [ADRC_W-1:0]  CADDR  = 8'h21;
  localparam logic [ADRC_W-1:0]  DADDR  = 8'h42;
  localparam logic [SRAMC_W-1:0] CWDATA = 96'hC0C0_0000_1111_2222_3333_4444;
  localparam logic [SRAMC_W-1:0] DWDATA = 96'hD0D0_5555_6666_7777_8888_9999;
  localparam logic [SRAMC_N-1:0] CMASK  = 2'b01;
  localparam logic [SRAMC_N-1:0] DMASK  = 2'b10;

  logic               clk = 1'b0;
  logic               rst;
  logic               core_req, core_wren, core_gnt, core_rvalid;
  logic [ADRC_W-1:0]  core_addr;
  logic [SRAMC_W-1:0] core_wdata, core_rdata;
  logic [SRAMC_N-1:0] core_wmask;
  logic               dma_req, dma_wren, dma_gnt, dma_rvalid;
  logic [ADRC_W-1:0]  dma_addr;
  logic [SRAMC_W-1:0] dma_wdata, dma_rdata;
  logic [SRAMC_N-1:0] dma_wmask;
  logic               sram_rden, sram_wren;
  logic [ADRC_W-1:0]  sram_addr;
  logic [SRAMC_W-1:0] sram_wdata, sram_rdata;
  logic [SRAMC_N-1:0] sram_wmask;
  logic [WAIT_W-1:0]  max_wait;
  logic               cnt_clear;
  logic [15:0]        conflict_cnt;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  always #5 clk = ~clk;

  sramc_port_arbiter #(
    .SRAMC_W(SRAMC_W), .ADRC_W(ADRC_W), .SRAMC_N(SRAMC_N), .WAIT_W(WAIT_W)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .i_core_req(core_req), .i_core_wren(core_wren), .i_core_addr(core_addr),
    .i_core_wdata(core_wdata), .i_core_wmask(core_wmask),
    .o_core_gnt(core_gnt), .o_core_rvalid(core_rvalid), .o_core_rdata(core_rdata),
    .i_dma_req(dma_req), .i_dma_wren(dma_wren), .i_dma_addr(dma_addr),
    .i_dma_wdata(dma_wdata), .i_dma_wmask(dma_wmask),
    .o_dma_gnt(dma_gnt), .o_dma_rvalid(dma_rvalid), .o_dma_rdata(dma_rdata),
    .o_sram_rden(sram_rden), .o_sram_wren(sram_wren), .o_sram_addr(sram_addr),
    .o_sram_wdata(sram_wdata), .o_sram_wmask(sram_wmask), .i_sram_rdata(sram_rdata),
    .i_max_wait(max_wait), .i_cnt_clear(cnt_clear), .o_conflict_cnt(conflict_cnt)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // src: 0 = no grant, 1 = core, 2 = DMA
  typedef struct {
    logic       creq, cwr, dreq, dwr;
    logic       e_cg, e_dg, e_rden, e_wren;
    logic [1:0] e_src;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [SRAMC_W-1:0] rd_vals[5];
    logic [SRAMC_W-1:0] e_wdata;
    logic [ADRC_W-1:0]  e_addr;
    logic [SRAMC_N-1:0] e_mask;
    logic               dma_seen;

    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0,  1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0,  1'b1, 1'b0, 1'b1, 1'b0, 2'd1};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b0,  1'b1, 1'b0, 1'b0, 1'b1, 2'd1};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b0,  1'b0, 1'b1, 1'b1, 1'b0, 2'd2};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b1,  1'b0, 1'b1, 1'b0, 1'b1, 2'd2};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b1,  1'b1, 1'b0, 1'b1, 1'b0, 2'd1};
    vecs[6] = '{1'b1, 1'b1, 1'b1, 1'b0,  1'b1, 1'b0, 1'b0, 1'b1, 2'd1};
    vecs[7] = '{1'b1, 1'b1, 1'b1, 1'b1,  1'b1, 1'b0, 1'b0, 1'b1, 2'd1};

    core_req = 0; core_wren = 0; core_addr = CADDR; core_wdata = CWDATA; core_wmask = CMASK;
    dma_req  = 0; dma_wren  = 0; dma_addr  = DADDR; dma_wdata  = DWDATA; dma_wmask  = DMASK;
    sram_rdata = '0; max_wait = '0; cnt_clear = 0;

    // Reset state
    do_reset();
    check("rst_core_gnt", core_gnt, 0);
    check("rst_dma_gnt", dma_gnt, 0);
    check("rst_sram_rden", sram_rden, 0);
    check("rst_core_rvalid", core_rvalid, 0);
    check("rst_dma_rvalid", dma_rvalid, 0);
    check("rst_core_rdata", core_rdata, 0);
    check("rst_conflict", conflict_cnt, 0);

    // Table: strict core priority, grant and SRAM mux per request pattern
    for (int i = 0; i < 8; i++) begin
      core_req = vecs[i].creq; core_wren = vecs[i].cwr;
      dma_req  = vecs[i].dreq; dma_wren  = vecs[i].dwr;
      #1;
      case (vecs[i].e_src)
        2'd1:    begin e_addr = CADDR; e_wdata = CWDATA; e_mask = CMASK; end
        2'd2:    begin e_addr = DADDR; e_wdata = DWDATA; e_mask = DMASK; end
        default: begin e_addr = '0;    e_wdata = '0;     e_mask = '0;    end
      endcase
      check($sformatf("v%0d_core_gnt", i), core_gnt, vecs[i].e_cg);
      check($sformatf("v%0d_dma_gnt", i), dma_gnt, vecs[i].e_dg);
      check($sformatf("v%0d_rden", i), sram_rden, vecs[i].e_rden);
      check($sformatf("v%0d_wren", i), sram_wren, vecs[i].e_wren);
      check($sformatf("v%0d_addr", i), sram_addr, e_addr);
      check($sformatf("v%0d_wdata", i), sram_wdata, e_wdata);
      check($sformatf("v%0d_wmask", i), sram_wmask, e_mask);
      tick();
    end
    core_req = 0; dma_req = 0; core_wren = 0; dma_wren = 0;
    do_reset();

    // Core-only read at 0x10, data returned next cycle
    core_req = 1; core_addr = 8'h10;
    #1;
    check("rd_core_gnt", core_gnt, 1);
    check("rd_rden", sram_rden, 1);
    check("rd_addr", sram_addr, 8'h10);
    tick();
    core_req = 0; core_addr = CADDR;
    sram_rdata = 96'h1234_5678_9ABC_DEF0_0F1E_2D3C;
    #1;
    check("rd_core_rvalid", core_rvalid, 1);
    check("rd_core_rdata", core_rdata, 96'h1234_5678_9ABC_DEF0_0F1E_2D3C);
    check("rd_dma_rvalid", dma_rvalid, 0);
    check("rd_dma_rdata", dma_rdata, 0);
    tick();
    check("rd_core_rvalid_drop", core_rvalid, 0);
    check("rd_core_rdata_zero", core_rdata, 0);

    // Alternating core/DMA reads, each response routed to its owner
    for (int k = 0; k < 5; k++) begin
      rd_vals[k] = {32'hA5A5_0000 + k, 64'h0};
      core_req   = (k < 4) && (k % 2 == 0);
      dma_req    = (k < 4) && (k % 2 == 1);
      sram_rdata = rd_vals[k];
      #1;
      if (k > 0) begin
        if ((k - 1) % 2 == 0) begin
          check($sformatf("alt%0d_core_rvalid", k), core_rvalid, 1);
          check($sformatf("alt%0d_core_rdata", k), core_rdata, rd_vals[k]);
          check($sformatf("alt%0d_dma_rvalid", k), dma_rvalid, 0);
        end else begin
          check($sformatf("alt%0d_dma_rvalid", k), dma_rvalid, 1);
          check($sformatf("alt%0d_dma_rdata", k), dma_rdata, rd_vals[k]);
          check($sformatf("alt%0d_core_rvalid", k), core_rvalid, 0);
        end
      end
      tick();
    end
    sram_rdata = '0;

    // max_wait=3 under continuous contention: core,core,core,DMA
    do_reset();
    max_wait = 4'd3; core_req = 1; dma_req = 1;
    for (int i = 0; i < 8; i++) begin
      #1;
      check($sformatf("mw3_c%0d_dma_gnt", i), dma_gnt, (i % 4) == 3);
      check($sformatf("mw3_c%0d_core_gnt", i), core_gnt, (i % 4) != 3);
      check($sformatf("mw3_c%0d_conflict", i), conflict_cnt, i);
      tick();
    end
    check("mw3_conflict_end", conflict_cnt, 8);

    // max_wait=0: DMA never granted, wait counter saturates
    do_reset();
    max_wait = '0;
    dma_seen = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (dma_gnt || !core_gnt) dma_seen = 1;
      tick();
    end
    check("mw0_no_dma_grant", dma_seen, 0);
    check("mw0_wait_sat", dut.wait_q, 4'hF);

    // DMA_TURN entered but DMA drops its request
    do_reset();
    max_wait = 4'd2; core_req = 1; dma_req = 1;
    tick();
    tick();
    dma_req = 0;
    #1;
    check("turn_drop_core_gnt", core_gnt, 1);
    check("turn_drop_dma_gnt", dma_gnt, 0);
    tick();
    dma_req = 1;
    #1;
    check("turn_back_core_gnt", core_gnt, 1);
    check("turn_back_dma_gnt", dma_gnt, 0);
    tick();

    // Reset at the edge that would register a DMA read
    core_req = 1; dma_req = 1; max_wait = '0;
    tick();
    tick();
    core_req = 0; dma_req = 1; dma_wren = 0;
    #1;
    check("rstrd_dma_gnt", dma_gnt, 1);
    rst = 1;
    tick();
    rst = 0; dma_req = 0;
    #1;
    check("rstrd_dma_rvalid", dma_rvalid, 0);
    check("rstrd_dma_rdata", dma_rdata, 0);
    check("rstrd_conflict", conflict_cnt, 0);

    // Conflict counter saturation and clear-over-increment
    core_req = 1; dma_req = 1;
    repeat (70000) @(posedge clk);
    #1;
    check("sat_conflict", conflict_cnt, 16'hFFFF);
    cnt_clear = 1;
    tick();
    cnt_clear = 0;
    check("clr_conflict", conflict_cnt, 0);
    tick();
    check("clr_then_inc", conflict_cnt, 1);
    core_req = 0; dma_req = 0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
